// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared widths, transfer constants and FSM encoding for the two-master bus arbiter
package bus_pkg;

    localparam int REQ_LEN_W = 3;
    localparam int MASK_W    = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;

    localparam logic [2:0] SIZ_WORD = 3'd2;

    typedef enum logic {
        TT_READ  = 1'b0,
        TT_WRITE = 1'b1
    } tt_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_e;

    // Zero-length requests still move one beat; oversize ones are cut to the legal maximum.
    function automatic logic [REQ_LEN_W-1:0] burst_beats(input logic [REQ_LEN_W-1:0] len,
                                                         input logic [REQ_LEN_W-1:0] max_len);
        if (len == '0)
            return REQ_LEN_W'(1);
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/bus_if.sv
// rtl/bus_if.sv - request/write/read handshake bundle shared by masters and the downstream port
interface bus_if;
    import bus_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [REQ_LEN_W-1:0] req_len;
    logic [MASK_W-1:0]    req_mask;
    logic [ADDR_W-1:0]    req_addr;
    logic                 req_we;
    logic                 write_valid;
    logic [DATA_W-1:0]    write_data;
    logic                 read_valid;
    logic [DATA_W-1:0]    read_data;
    logic                 read_ack;

    modport master (
        output req_valid, req_len, req_mask, req_addr, req_we,
        output write_valid, write_data, read_ack,
        input  req_ready, read_valid, read_data
    );

    modport slave (
        input  req_valid, req_len, req_mask, req_addr, req_we,
        input  write_valid, write_data, read_ack,
        output req_ready, read_valid, read_data
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input grant picker with last-grant pointer and optional fixed M0 priority
module rr_arb2 #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       last_m0,
    output logic [1:0] pick
);

    logic m1_first;

    // Pointer moves only when a burst retires, so a waiting master is served next.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            m1_first <= 1'b0;
        else if (done)
            m1_first <= last_m0;
    end

    always_comb begin
        pick = req;
        if (req == 2'b11)
            pick = (PRIO_FIXED || !m1_first) ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - shares one downstream request port between two bus masters, burst-atomic grants
module bus_arbiter
    import bus_pkg::*;
#(
    parameter bit PRIO_FIXED = 1'b0,
    parameter int MAX_LEN    = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    bus_if.slave       m0,
    bus_if.slave       m1,
    bus_if.master      s,
    output logic [1:0] gnt,
    output logic       busy
);

    localparam logic [REQ_LEN_W-1:0] MAX_BEATS = REQ_LEN_W'(MAX_LEN);

    state_e               state, state_n;
    logic [1:0]           gnt_n;
    logic [REQ_LEN_W-1:0] beats, beats_n;
    logic                 we_q, we_n;
    logic [1:0]           pick;
    logic                 hs, beat, done, in_data;
    logic                 sel_wv, sel_ack;
    logic [DATA_W-1:0]    sel_wdata;

    rr_arb2 #(.PRIO_FIXED(PRIO_FIXED)) u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req     ({m1.req_valid, m0.req_valid}),
        .done    (done),
        .last_m0 (gnt[0]),
        .pick    (pick)
    );

    always_comb begin
        s.req_valid = 1'b0;
        s.req_len   = '0;
        s.req_mask  = '0;
        s.req_addr  = '0;
        s.req_we    = 1'b0;
        sel_wv      = 1'b0;
        sel_wdata   = '0;
        sel_ack     = 1'b0;
        if (gnt[0]) begin
            s.req_valid = m0.req_valid;
            s.req_len   = m0.req_len;
            s.req_mask  = m0.req_mask;
            s.req_addr  = m0.req_addr;
            s.req_we    = m0.req_we;
            sel_wv      = m0.write_valid;
            sel_wdata   = m0.write_data;
            sel_ack     = m0.read_ack;
        end else if (gnt[1]) begin
            s.req_valid = m1.req_valid;
            s.req_len   = m1.req_len;
            s.req_mask  = m1.req_mask;
            s.req_addr  = m1.req_addr;
            s.req_we    = m1.req_we;
            sel_wv      = m1.write_valid;
            sel_wdata   = m1.write_data;
            sel_ack     = m1.read_ack;
        end
        if (state != REQ)
            s.req_valid = 1'b0;
    end

    assign hs           = (state == REQ) & s.req_valid & s.req_ready;
    assign m0.req_ready = hs & gnt[0];
    assign m1.req_ready = hs & gnt[1];

    // Beat strobes only count while a burst is open, so the counter cannot underflow.
    assign in_data       = (state == DATA);
    assign s.write_valid = in_data & we_q & sel_wv;
    assign s.write_data  = (in_data & we_q) ? sel_wdata : '0;
    assign s.read_ack    = in_data & ~we_q & sel_ack;
    assign m0.read_valid = in_data & ~we_q & gnt[0] & s.read_valid;
    assign m1.read_valid = in_data & ~we_q & gnt[1] & s.read_valid;
    assign m0.read_data  = gnt[0] ? s.read_data : '0;
    assign m1.read_data  = gnt[1] ? s.read_data : '0;

    assign beat = s.write_valid | s.read_ack;
    assign done = beat & (beats == REQ_LEN_W'(1));
    assign busy = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            gnt   <= 2'b00;
            beats <= '0;
            we_q  <= 1'b0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            beats <= beats_n;
            we_q  <= we_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        beats_n = beats;
        we_n    = we_q;
        case (state)
            IDLE: begin
                if (pick != 2'b00) begin
                    gnt_n   = pick;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (hs) begin
                    beats_n = burst_beats(s.req_len, MAX_BEATS);
                    we_n    = s.req_we;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (beat) begin
                    if (done) begin
                        state_n = IDLE;
                        gnt_n   = 2'b00;
                        beats_n = '0;
                    end else begin
                        beats_n = beats - REQ_LEN_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter, round-robin and fixed-priority instances
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam logic [31:0] RD_PAT = 32'hDA7A_5EED;

    typedef struct {
        logic [1:0]  gnt;
        logic [31:0] addr;
        logic [2:0]  len;
        logic        we;
    } exp_t;

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b0;
    logic [1:0] gnt, f_gnt;
    logic       busy, f_busy;

    always #5 clk_i = ~clk_i;

    bus_if m0();
    bus_if m1();
    bus_if s();
    bus_if f_m0();
    bus_if f_m1();
    bus_if f_s();

    bus_arbiter #(.PRIO_FIXED(1'b0), .MAX_LEN(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .m0     (m0),
        .m1     (m1),
        .s      (s),
        .gnt    (gnt),
        .busy   (busy)
    );

    bus_arbiter #(.PRIO_FIXED(1'b1), .MAX_LEN(4)) dut_fix (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .m0     (f_m0),
        .m1     (f_m1),
        .s      (f_s),
        .gnt    (f_gnt),
        .busy   (f_busy)
    );

    // Fixed-priority instance: both masters request single-beat reads forever.
    assign f_m0.req_valid   = 1'b1;
    assign f_m0.req_len     = 3'd1;
    assign f_m0.req_mask    = 4'hF;
    assign f_m0.req_addr    = 32'h0000_0100;
    assign f_m0.req_we      = 1'b0;
    assign f_m0.write_valid = 1'b0;
    assign f_m0.write_data  = '0;
    assign f_m0.read_ack    = 1'b1;
    assign f_m1.req_valid   = 1'b1;
    assign f_m1.req_len     = 3'd1;
    assign f_m1.req_mask    = 4'hF;
    assign f_m1.req_addr    = 32'h0000_0200;
    assign f_m1.req_we      = 1'b0;
    assign f_m1.write_valid = 1'b0;
    assign f_m1.write_data  = '0;
    assign f_m1.read_ack    = 1'b1;
    assign f_s.req_ready    = 1'b1;
    assign f_s.read_valid   = 1'b1;
    assign f_s.read_data    = RD_PAT;

    exp_t        exp_q[$];
    logic [31:0] wd_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rdy_cnt[2] = '{0, 0};
    int          f_cnt[2] = '{0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        exp_t        e;
        logic [31:0] w;
        if (rst_ni) begin
            if (s.req_valid && s.req_ready) begin
                check("sb_req_queue_empty", 32'(exp_q.size() == 0), 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_gnt", 32'(gnt), 32'(e.gnt));
                    check("sb_addr", s.req_addr, e.addr);
                    check("sb_len", 32'(s.req_len), 32'(e.len));
                    check("sb_we", 32'(s.req_we), 32'(e.we));
                    check("sb_ready", 32'({m1.req_ready, m0.req_ready}), 32'(e.gnt));
                end
            end
            if (s.write_valid) begin
                check("sb_wd_queue_empty", 32'(wd_q.size() == 0), 0);
                if (wd_q.size() != 0) begin
                    w = wd_q.pop_front();
                    check("sb_wdata", s.write_data, w);
                end
            end
            if (m0.read_valid || m1.read_valid) begin
                check("rd_owner", 32'({m1.read_valid, m0.read_valid} & ~gnt), 0);
                check("rd_data", m0.read_valid ? m0.read_data : m1.read_data, RD_PAT);
            end
            rdy_cnt[0] <= rdy_cnt[0] + int'(m0.req_ready);
            rdy_cnt[1] <= rdy_cnt[1] + int'(m1.req_ready);
            if (f_s.req_valid && f_s.req_ready) begin
                f_cnt[0] <= f_cnt[0] + int'(f_gnt[0]);
                f_cnt[1] <= f_cnt[1] + int'(f_gnt[1]);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int m, input bit v, input logic [31:0] a, input logic [2:0] l, input bit we);
        if (m == 0) begin
            m0.req_valid = v; m0.req_addr = a; m0.req_len = l; m0.req_we = we; m0.req_mask = 4'hF;
        end else begin
            m1.req_valid = v; m1.req_addr = a; m1.req_len = l; m1.req_we = we; m1.req_mask = 4'hF;
        end
    endtask

    task automatic set_ack(input int m, input bit v);
        if (m == 0) m0.read_ack = v; else m1.read_ack = v;
    endtask

    task automatic set_wv(input int m, input bit v, input logic [31:0] d);
        if (m == 0) begin m0.write_valid = v; m0.write_data = d; end
        else begin m1.write_valid = v; m1.write_data = d; end
    endtask

    task automatic push_exp(input int m, input logic [31:0] a, input logic [2:0] l, input bit we);
        exp_t e;
        e.gnt = (m == 0) ? 2'b01 : 2'b10;
        e.addr = a; e.len = l; e.we = we;
        exp_q.push_back(e);
    endtask

    // Returns just after the handshake edge; c is the cycle in which req_ready was seen.
    task automatic wait_ready(input int m, output int c);
        bit seen = 1'b0;
        c = -1;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk_i);
            if ((m == 0) ? m0.req_ready : m1.req_ready) begin
                seen = 1'b1;
                c = cyc;
            end
        end
        if (!seen) check("ready_timeout", 0, 1);
        tick();
    endtask

    task automatic do_req(input int m, input logic [31:0] a, input logic [2:0] l, input bit we);
        int c;
        set_req(m, 1'b1, a, l, we);
        wait_ready(m, c);
        set_req(m, 1'b0, 32'h0, 3'd0, 1'b0);
    endtask

    task automatic rd_txn(input int m, input logic [31:0] a);
        do_req(m, a, 3'd1, 1'b0);
        set_ack(m, 1'b1);
        tick();
        set_ack(m, 1'b0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int beat4, rc, b0, b1;
        set_req(0, 1'b0, 32'h0, 3'd0, 1'b0);
        set_req(1, 1'b0, 32'h0, 3'd0, 1'b0);
        set_ack(0, 1'b0); set_ack(1, 1'b0);
        set_wv(0, 1'b0, 32'h0); set_wv(1, 1'b0, 32'h0);
        s.req_ready = 1'b1; s.read_valid = 1'b1; s.read_data = RD_PAT;

        // Reset state
        rst_ni = 1'b0;
        repeat (2) tick();
        @(negedge clk_i);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_outs", 32'({s.req_valid, s.write_valid, s.read_ack, m0.req_ready,
                              m1.req_ready, m0.read_valid, m1.read_valid}), 0);
        tick();
        rst_ni = 1'b1;

        // Beat strobes in IDLE are ignored
        set_wv(0, 1'b1, 32'hDEAD); set_ack(0, 1'b1);
        @(negedge clk_i);
        check("idle_beats_ignored", 32'({s.write_valid, s.read_ack, busy}), 0);
        tick();
        set_wv(0, 1'b0, 32'h0); set_ack(0, 1'b0);

        // Only M0, single-beat read
        push_exp(0, 32'h4000_0010, 3'd1, 1'b0);
        set_req(0, 1'b1, 32'h4000_0010, 3'd1, 1'b0);
        @(negedge clk_i);
        check("t1_gnt_latency", 32'(gnt), 0);
        tick();
        @(negedge clk_i);
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_addr", s.req_addr, 32'h4000_0010);
        tick();
        set_req(0, 1'b0, 32'h0, 3'd0, 1'b0);
        set_ack(0, 1'b1);
        @(negedge clk_i);
        check("t1_rvalid", 32'({m1.read_valid, m0.read_valid}), 32'h1);
        tick();
        set_ack(0, 1'b0);
        @(negedge clk_i);
        check("t1_idle", 32'({gnt, busy}), 0);

        // Simultaneous requests alternate from M0-first
        tick();
        do_reset();
        b0 = rdy_cnt[0]; b1 = rdy_cnt[1];
        for (int rep = 0; rep < 2; rep++) begin
            push_exp(0, 32'h1000_0000 + 32'(rep * 16), 3'd1, 1'b0);
            push_exp(1, 32'h2000_0000 + 32'(rep * 16), 3'd1, 1'b0);
            fork
                rd_txn(0, 32'h1000_0000 + 32'(rep * 16));
                rd_txn(1, 32'h2000_0000 + 32'(rep * 16));
            join
        end
        @(negedge clk_i);
        check("t2_m0_ready_pulses", 32'(rdy_cnt[0] - b0), 2);
        check("t2_m1_ready_pulses", 32'(rdy_cnt[1] - b1), 2);

        // M0 arrives in the middle of M1's 4-beat write
        tick();
        push_exp(1, 32'h3000_0000, 3'd4, 1'b1);
        do_req(1, 32'h3000_0000, 3'd4, 1'b1);
        beat4 = 0;
        for (int i = 0; i < 4; i++) begin
            set_wv(1, 1'b1, 32'hA0 + 32'(i));
            wd_q.push_back(32'hA0 + 32'(i));
            if (i == 3) beat4 = cyc;
            @(negedge clk_i);
            check("t3_m0_held", 32'(m0.req_ready), 0);
            tick();
            if (i == 1) begin
                push_exp(0, 32'h4000_0100, 3'd1, 1'b0);
                set_req(0, 1'b1, 32'h4000_0100, 3'd1, 1'b0);
            end
        end
        set_wv(1, 1'b0, 32'h0);
        wait_ready(0, rc);
        set_req(0, 1'b0, 32'h0, 3'd0, 1'b0);
        check("t3_wait_cycles", 32'(rc - beat4), 2);
        set_ack(0, 1'b1);
        tick();
        set_ack(0, 1'b0);

        // Reset in the middle of a 2-beat read
        tick();
        push_exp(0, 32'h5000_0000, 3'd2, 1'b0);
        do_req(0, 32'h5000_0000, 3'd2, 1'b0);
        set_ack(0, 1'b1);
        tick();
        set_ack(0, 1'b0);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("t4_rst_gnt_busy", 32'({gnt, busy}), 0);
        check("t4_rst_outs", 32'({s.req_valid, s.write_valid, s.read_ack, m0.req_ready,
                                 m1.req_ready, m0.read_valid, m1.read_valid}), 0);
        tick();
        push_exp(1, 32'h6000_0000, 3'd1, 1'b0);
        do_req(1, 32'h6000_0000, 3'd1, 1'b0);
        set_ack(1, 1'b1);
        @(negedge clk_i);
        check("t4_m1_gnt", 32'(gnt), 32'h2);
        tick();
        set_ack(1, 1'b0);

        // len=0 is one beat, len=7 is clamped to four
        tick();
        push_exp(0, 32'h7000_0000, 3'd0, 1'b1);
        do_req(0, 32'h7000_0000, 3'd0, 1'b1);
        set_wv(0, 1'b1, 32'hB0);
        wd_q.push_back(32'hB0);
        @(negedge clk_i);
        check("t5_len0_busy", 32'(busy), 1);
        tick();
        set_wv(0, 1'b0, 32'h0);
        @(negedge clk_i);
        check("t5_len0_done", 32'(busy), 0);
        tick();
        push_exp(0, 32'h7000_0040, 3'd7, 1'b1);
        do_req(0, 32'h7000_0040, 3'd7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            set_wv(0, 1'b1, 32'hC0 + 32'(i));
            wd_q.push_back(32'hC0 + 32'(i));
            @(negedge clk_i);
            check("t5_len7_busy", 32'(busy), 1);
            tick();
        end
        set_wv(0, 1'b0, 32'h0);
        @(negedge clk_i);
        check("t5_len7_done", 32'(busy), 0);

        repeat (30) tick();
        check("sb_req_left", 32'(exp_q.size()), 0);
        check("sb_wd_left", 32'(wd_q.size()), 0);
        check("fix_m1_never", 32'(f_cnt[1]), 0);
        check("fix_m0_served", 32'(f_cnt[0] > 10), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Two-master arbiter that shares the single downstream memory/peripheral request port between the CPU bus interface (M0) and a second bus master (M1, DMA or video fetch).
- Both masters use the same req/write/read handshake; the downstream slave sees one master at a time.
- A grant is held for the whole burst (req_len beats) and released only after the last beat.
- Sits between the masters and the memory controller/interconnect.

Parameters:
PRIO_FIXED, 0, 0 = round-robin between M0/M1; 1 = M0 always wins simultaneous requests.
MAX_LEN, 4, largest legal burst length in beats; a req_len above MAX_LEN is clamped to MAX_LEN.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  synchronous active-low reset
mN_req_valid  in  1  request from master N (N=0,1); held until accepted
mN_req_ready  out  1  request accepted (one-cycle pulse)
mN_req_len  in  3  burst length in beats
mN_req_mask  in  4  byte enables
mN_req_addr  in  32  byte address
mN_req_we  in  1  1 = write, 0 = read
mN_write_valid  in  1  write beat strobe
mN_write_data  in  32  write beat data
mN_read_valid  out  1  read beat available to master N
mN_read_data  out  32  read beat data
mN_read_ack  in  1  master N consumed the read beat
s_req_valid, s_req_len, s_req_mask, s_req_addr, s_req_we  out  1/3/4/32/1  downstream request
s_req_ready  in  1  downstream accepts request
s_write_valid, s_write_data  out  1/32  downstream write beat
s_read_valid, s_read_data  in  1/32  downstream read beat
s_read_ack  out  1  downstream read beat consumed
gnt  out  2  one-hot current grant; 00 = none
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_ni=0 at clk_i edge): state=IDLE, gnt=00, rr pointer = M0-first, beat counter=0. All outputs 0: s_req_valid, s_write_valid, s_read_ack, mN_req_ready, mN_read_valid. Reset mid-burst aborts the burst with no beats completed; masters must be reset together with the arbiter.
- States: IDLE, REQ, DATA.
- IDLE:
  - If any mN_req_valid, register gnt and go to REQ next cycle. Arbitration latency is 1 cycle.
  - Only M0 requesting → M0. Only M1 → M1.
  - Both requesting: with PRIO_FIXED=1, M0 wins. With PRIO_FIXED=0, the master not granted last wins; the pointer starts M0-first after reset.
- REQ:
  - s_req_* are muxed combinationally from the granted master.
  - Granted mN_req_ready = s_req_ready & s_req_valid. The other master's ready stays 0.
  - On the handshake, load beats = (len==0 ? 1 : min(len, MAX_LEN)), latch we, go to DATA.
  - s_req_valid drops the cycle after the handshake.
- DATA:
  - Write: s_write_valid/s_write_data = granted master's write_valid/write_data. Each write_valid decrements beats.
  - Read: granted mN_read_valid/read_data = s_read_valid/s_read_data, and s_read_ack = granted mN_read_ack. Each read_ack pulse decrements beats.
  - Non-granted master: read_valid=0, and its write_valid is ignored.
  - A beat event with beats==1 → IDLE next cycle. gnt clears and the rr pointer updates on that transition.
- Request ordering:
  - New requests are never sampled outside IDLE.
  - A master's req_valid that rises during another master's burst waits; it is served at the earliest 2 cycles after the last beat (IDLE, then REQ).
  - A master cannot be granted twice in a row while the other is requesting (round-robin mode).
- Beat events outside DATA are ignored; the counter cannot underflow.

Decomposition:
- Shared package bus_pkg: SIZ/TT constants, REQ_LEN_W=3, MASK_W=4, ADDR_W=32, DATA_W=32, and the state encoding IDLE/REQ/DATA.
- One natural sub-module: rr_arb2, a two-input grant picker with a last-grant pointer and fixed-priority override. The mux and beat counter stay in bus_arbiter.

Test Plan:
- Only M0: read, len=1, addr 0x4000_0010. → gnt=01 one cycle after req_valid; s_req_addr=0x4000_0010; one read_ack → IDLE; m1_read_valid stays 0.
- Both request in the same cycle, PRIO_FIXED=0, reps of len=1 reads. → grants alternate M0, M1, M0, M1; each m*_req_ready pulses exactly once per request.
- M1 4-beat write in progress; M0 requests after the 2nd write_valid. → M0 waits; m0_req_ready is not asserted until ≥2 cycles after M1's 4th write_valid; s_write_data matches M1 data 0xA0..0xA3.
- PRIO_FIXED=1, M0 and M1 continuously requesting. → M0 is granted every arbitration; M1 is never granted.
- M0 2-beat read with only 1 read_ack, then rst_ni=0 for 1 cycle. → next cycle all outputs 0, gnt=00, busy=0; a new M1 request is then granted normally.
- req_len=0 write, then req_len=7 write. → the first completes after 1 write_valid; the second completes after exactly 4 write_valid beats (clamped to MAX_LEN).
